rf_write_scheduler: RTL and testbench

Buffers register-file write-back requests from four result producers (ALU, logic, two shift units) and drives the four RF write ports (`select_r_i`, `data_i`, `enable_writing_i`) of `RF`. It owns one small FIFO per producer. It guarantees that no two RF write ports target the same address in one cycle. An aging rule prevents a producer from being starved by same-address conflicts.

---
 rtl/rf_write_scheduler.sv | 124 ++++++++++++
 tb/tb_rf_write_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rf_write_scheduler.sv
// Per-producer write-back FIFOs feeding four RF write ports with same-address conflict arbitration and aging.
// Optional RF_WRITE_SCHEDULER_ZERO_DROP_EN: address-0 writes are accepted but silently dropped (hardwired r0).
module rf_ws_lane #(
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  parameter int AGE_LIMIT = 3
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  output logic          ready,
  output logic          head_vld,
  output logic          aged,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] AGE = 3'(AGE_LIMIT);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  wb_req_t       mem [DEPTH];
  wb_req_t       head;
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [2:0]    stall;

  assign head_vld  = wr_ptr != rd_ptr;
  assign ready     = !((wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]));
  assign aged      = stall == AGE;
  assign head      = mem[rd_ptr[PW-1:0]];
  // Empty heads present zeros so idle ports never show stale data.
  assign head_addr = head_vld ? head.addr : '0;
  assign head_data = head_vld ? head.data : '0;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      stall  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop || !head_vld) stall <= '0;
      else if (!aged)       stall <= stall + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[PW-1:0]] <= '{addr: push_addr, data: push_data};
  end
endmodule

module rf_write_scheduler #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 4,
  parameter int AGE_LIMIT     = 3
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [3:0]                    src_valid_i,
  output logic [3:0]                    src_ready_o,
  input  logic [3:0][ADDRESS_WIDTH-1:0] src_addr_i,
  input  logic [3:0][WORD_WIDTH-1:0]    src_data_i,
  output logic [3:0][ADDRESS_WIDTH-1:0] select_r_o,
  output logic [3:0][WORD_WIDTH-1:0]    data_o,
  output logic [3:0]                    enable_writing_o,
  output logic                          idle_o
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] push, head_vld, aged, win;

  always_comb begin
    for (int p = 0; p < NUM_LANES; p++) begin
`ifdef RF_WRITE_SCHEDULER_ZERO_DROP_EN
      push[p] = src_valid_i[p] && src_ready_o[p] && (src_addr_i[p] != '0);
`else
      push[p] = src_valid_i[p] && src_ready_o[p];
`endif
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rf_ws_lane #(
      .AW(ADDRESS_WIDTH), .DW(WORD_WIDTH), .DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)
    ) u_lane (
      .clk_i     (clk_i),
      .arst_i    (arst_i),
      .push      (push[g]),
      .pop       (win[g]),
      .push_addr (src_addr_i[g]),
      .push_data (src_data_i[g]),
      .ready     (src_ready_o[g]),
      .head_vld  (head_vld[g]),
      .aged      (aged[g]),
      .head_addr (select_r_o[g]),
      .head_data (data_o[g])
    );
  end

  // A head loses if any other same-address head is aged while it is not,
  // or shares its age class and has a lower index.
  always_comb begin
    for (int p = 0; p < NUM_LANES; p++) begin
      win[p] = head_vld[p];
      for (int q = 0; q < NUM_LANES; q++) begin
        if (q != p && head_vld[q] && select_r_o[q] == select_r_o[p] &&
            ((aged[q] && !aged[p]) || (aged[q] == aged[p] && q < p)))
          win[p] = 1'b0;
      end
    end
  end

  assign enable_writing_o = win;
  assign idle_o           = ~|head_vld;
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler with a behavioural RF on the write ports.
module tb_rf_write_scheduler;
  logic              clk_i, arst_i;
  logic [3:0]        src_valid_i, src_ready_o, enable_writing_o;
  logic [3:0][4:0]   src_addr_i, select_r_o;
  logic [3:0][31:0]  src_data_i, data_o;
  logic              idle_o;

  logic [31:0] rf [32];
  bit          tb_init = 0;
  int          n_cmp = 0, n_err = 0;

  rf_write_scheduler dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_addr_i(src_addr_i), .src_data_i(src_data_i),
    .select_r_o(select_r_o), .data_o(data_o),
    .enable_writing_o(enable_writing_o), .idle_o(idle_o)
  );

  initial clk_i = 0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!tb_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA5A5_0000 | i;
    end else begin
      for (int p = 0; p < 4; p++)
        if (enable_writing_o[p]) rf[select_r_o[p]] <= data_o[p];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    arst_i = 0; src_valid_i = '0; src_addr_i = '0; src_data_i = '0;
    #1;
    chk("rst_ready", src_ready_o, 4'hF);
    chk("rst_idle",  idle_o, 1);
    chk("rst_en",    enable_writing_o, 0);
    chk("rst_sel",   select_r_o, 0);
    chk("rst_data",  data_o, 0);
    repeat (2) @(posedge clk_i);
    tb_init = 1;
    @(negedge clk_i);
    arst_i = 1;
    step();

    // four distinct addresses, all written in one cycle
    for (int p = 0; p < 4; p++) begin
      src_valid_i[p] = 1; src_addr_i[p] = 5'(p); src_data_i[p] = p;
    end
    step();
    src_valid_i = '0;
    chk("nc_en", enable_writing_o, 4'hF);
    for (int p = 0; p < 4; p++) chk("nc_sel", select_r_o[p], p);
    step();
    for (int p = 0; p < 4; p++) chk("nc_rf", rf[p], p);
    chk("nc_idle", idle_o, 1);

    // same-address conflict: port 0 first, then port 2
    src_valid_i = 4'b0101;
    src_addr_i[0] = 5; src_data_i[0] = 7;
    src_addr_i[2] = 5; src_data_i[2] = 9;
    step();
    src_valid_i = '0;
    chk("cf_en1",   enable_writing_o, 4'b0001);
    chk("cf_data1", data_o[0], 7);
    step();
    chk("cf_en2",   enable_writing_o, 4'b0100);
    chk("cf_rf1",   rf[5], 7);
    step();
    chk("cf_en3",   enable_writing_o, 0);
    chk("cf_rf2",   rf[5], 9);

    // aging: port 1 starved by a steady stream from port 0
    src_valid_i = 4'b0011;
    src_addr_i[0] = 6; src_data_i[0] = 'h100;
    src_addr_i[1] = 6; src_data_i[1] = 'h200;
    step();
    src_valid_i[1] = 0;
    for (int i = 1; i <= 3; i++) begin
      chk("age_stall_en", enable_writing_o, 4'b0001);
      src_data_i[0] = 'h100 + i;
      step();
    end
    src_valid_i = '0;
    chk("age_win_en",   enable_writing_o, 4'b0010);
    chk("age_win_data", data_o[1], 'h200);
    step();
    chk("age_after_en", enable_writing_o, 4'b0001);
    chk("age_after_d",  data_o[0], 'h103);
    chk("age_rf1",      rf[6], 'h200);
    step();
    chk("age_rf2",  rf[6], 'h103);
    chk("age_idle", idle_o, 1);

    // fill port 3 behind a port-0 conflict
    src_valid_i = 4'b1001;
    src_addr_i[0] = 4; src_data_i[0] = 'h500;
    src_addr_i[3] = 4; src_data_i[3] = 'h400;
    step();
    for (int i = 1; i <= 3; i++) begin
      chk("full_en_pre",  enable_writing_o, 4'b0001);
      chk("full_rdy_pre", src_ready_o[3], 1);
      src_data_i[0] = 'h500 + i; src_data_i[3] = 'h400 + i;
      step();
    end
    src_valid_i = '0;
    chk("full_rdy",  src_ready_o, 4'b0111);
    chk("full_en",   enable_writing_o, 4'b1000);
    chk("full_d",    data_o[3], 'h400);
    step();
    chk("full_rdy_back", src_ready_o, 4'hF);
    chk("full_p0_en",    enable_writing_o, 4'b0001);
    chk("full_p0_d",     data_o[0], 'h503);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("drain_en", enable_writing_o, 4'b1000);
      chk("drain_d",  data_o[3], 'h400 + k);
    end
    step();
    chk("drain_idle", idle_o, 1);
    chk("drain_rf",   rf[4], 'h403);

    // eight back-to-back entries through port 3, wrapping the pointers twice
    for (int i = 0; i < 8; i++) begin
      src_valid_i[3] = 1; src_addr_i[3] = 5'(8 + i); src_data_i[3] = 'h300 + i;
      step();
      chk("wrap_en",  enable_writing_o, 4'b1000);
      chk("wrap_sel", select_r_o[3], 8 + i);
      chk("wrap_d",   data_o[3], 'h300 + i);
    end
    src_valid_i = '0;
    step();
    for (int i = 0; i < 8; i++) chk("wrap_rf", rf[8 + i], 'h300 + i);
    chk("wrap_idle", idle_o, 1);

`ifdef RF_WRITE_SCHEDULER_ZERO_DROP_EN
    src_valid_i[1] = 1; src_addr_i[1] = 0; src_data_i[1] = 5;
    #1;
    chk("zd_ready", src_ready_o[1], 1);
    step();
    src_valid_i = '0;
    chk("zd_en",   enable_writing_o[1], 0);
    chk("zd_idle", idle_o, 1);
    step();
    chk("zd_rf",   rf[0], 0);
`endif

    // reset with entries queued in every FIFO
    src_valid_i = 4'hF;
    for (int p = 0; p < 4; p++) begin
      src_addr_i[p] = 10; src_data_i[p] = 'h600 + p;
    end
    step();
    for (int p = 0; p < 4; p++) src_data_i[p] = 'h610 + p;
    step();
    src_valid_i = '0;
    chk("mr_en_pre", enable_writing_o, 4'b0001);
    chk("mr_idle_pre", idle_o, 0);
    #2 arst_i = 0;
    #1;
    chk("mr_en",    enable_writing_o, 0);
    chk("mr_sel",   select_r_o, 0);
    chk("mr_data",  data_o, 0);
    chk("mr_idle",  idle_o, 1);
    chk("mr_ready", src_ready_o, 4'hF);
    @(posedge clk_i);
    @(negedge clk_i);
    arst_i = 1;
    step();
    step();
    chk("mr_rf",       rf[10], 'h600);
    chk("mr_idle_end", idle_o, 1);
    chk("mr_en_end",   enable_writing_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
